// File: rtl/miet_ic_pkg.sv
// Shared types and constants for the DMEM-to-peripheral AXI4 interconnect.
package miet_ic_pkg;

    localparam logic [31:0] IC_X2P_BASE    = 32'h0000_0000;
    localparam logic [31:0] IC_UART_BASE   = 32'h0000_1000;
    localparam logic [31:0] IC_REGION_SIZE = 32'h0000_1000;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {TGT_X2P, TGT_UART, TGT_DECERR} tgt_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

endpackage

// File: rtl/miet_axi_interconnect_if.sv
// Full AXI4 channel bundle; "master" is the side issuing AW/W/AR, "slave" answers with B/R.
interface miet_axi_interconnect_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 4
);
    logic [ID_WIDTH-1:0]     awid,   arid,   bid,   rid;
    logic [ADDR_WIDTH-1:0]   awaddr, araddr;
    logic [7:0]              awlen,  arlen;
    logic [2:0]              awsize, arsize, awprot, arprot;
    logic [1:0]              awburst, arburst, bresp, rresp;
    logic                    awlock, arlock;
    logic [3:0]              awcache, arcache;
    logic [USER_WIDTH-1:0]   awuser, aruser;
    logic                    awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic                    arvalid, arready, rvalid, rready, rlast;
    logic [DATA_WIDTH-1:0]   wdata, rdata;
    logic [DATA_WIDTH/8-1:0] wstrb;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awuser, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, aruser, arvalid,
        output rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awuser, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, aruser, arvalid,
        input  rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/miet_ic_decerr_slave.sv
// Default responder for unmapped addresses: sinks writes and answers every beat with DECERR.
module miet_ic_decerr_slave
    import miet_ic_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic                  wlast,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [7:0]            arlen,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast
);
    w_state_t            ph_q, ph_d;
    logic [ID_WIDTH-1:0] bid_q, bid_d, rid_q, rid_d;
    logic                rbusy_q, rbusy_d;
    logic [7:0]          cnt_q, cnt_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ph_q    <= W_IDLE;
            bid_q   <= '0;
            rid_q   <= '0;
            rbusy_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ph_q    <= ph_d;
            bid_q   <= bid_d;
            rid_q   <= rid_d;
            rbusy_q <= rbusy_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        ph_d    = ph_q;
        bid_d   = bid_q;
        rid_d   = rid_q;
        rbusy_d = rbusy_q;
        cnt_d   = cnt_q;
        case (ph_q)
            W_IDLE:  if (awvalid) begin bid_d = awid; ph_d = W_DATA; end
            W_DATA:  if (wvalid && wlast) ph_d = W_RESP;
            W_RESP:  if (bready) ph_d = W_IDLE;
            default: ph_d = W_IDLE;
        endcase
        // cnt_q counts remaining beats down; terminal count marks the last beat
        if (!rbusy_q) begin
            if (arvalid) begin rbusy_d = 1'b1; rid_d = arid; cnt_d = arlen; end
        end else if (rready) begin
            if (cnt_q == 8'd0) rbusy_d = 1'b0;
            else               cnt_d   = cnt_q - 8'd1;
        end
    end

    assign awready = (ph_q == W_IDLE);
    assign wready  = (ph_q == W_DATA);
    assign bvalid  = (ph_q == W_RESP);
    assign bid     = bid_q;
    assign bresp   = bvalid ? RESP_DECERR : RESP_OKAY;
    assign arready = ~rbusy_q;
    assign rvalid  = rbusy_q;
    assign rid     = rid_q;
    assign rdata   = '0;
    assign rresp   = rbusy_q ? RESP_DECERR : RESP_OKAY;
    assign rlast   = rbusy_q && (cnt_q == 8'd0);
endmodule

// File: rtl/miet_axi_interconnect.sv
// 1-to-2 AXI4 router: DMEM -> X2P (target 0) / UART (target 1), DECERR for anything else.
// state  | meaning
// W_IDLE | decode awaddr, pass AW to the decoded target
// W_DATA | W beats go to the latched target until wlast
// W_RESP | B from the latched target back to DMEM
// R_IDLE | decode araddr, pass AR to the decoded target
// R_DATA | R beats from the latched target until rlast
module miet_axi_interconnect
    import miet_ic_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          ID_WIDTH    = 4,
    parameter logic [31:0] X2P_BASE    = IC_X2P_BASE,
    parameter logic [31:0] UART_BASE   = IC_UART_BASE,
    parameter logic [31:0] REGION_SIZE = IC_REGION_SIZE
) (
    input logic                    i_clk,
    input logic                    i_rst,
    miet_axi_interconnect_if.slave  s_if,
    miet_axi_interconnect_if.master m0_if,
    miet_axi_interconnect_if.master m1_if
);
    localparam logic [ADDR_WIDTH-1:0] RMASK = ~(ADDR_WIDTH'(REGION_SIZE) - ADDR_WIDTH'(1));

    function automatic tgt_t decode(input logic [ADDR_WIDTH-1:0] a);
        if ((a & RMASK) == ADDR_WIDTH'(X2P_BASE))       decode = TGT_X2P;
        else if ((a & RMASK) == ADDR_WIDTH'(UART_BASE)) decode = TGT_UART;
        else                                            decode = TGT_DECERR;
    endfunction

    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;
    tgt_t     wsel_q, wsel_d, rsel_q, rsel_d, aw_tgt, ar_tgt;

    logic                  de_awvalid, de_awready, de_wvalid, de_wready, de_bvalid, de_bready;
    logic                  de_arvalid, de_arready, de_rvalid, de_rready, de_rlast;
    logic [ID_WIDTH-1:0]   de_bid, de_rid;
    logic [1:0]            de_bresp, de_rresp;
    logic [DATA_WIDTH-1:0] de_rdata;

    assign aw_tgt = decode(s_if.awaddr);
    assign ar_tgt = decode(s_if.araddr);

    // Payload fans out to both targets untouched; only valid/ready are steered.
    assign {m0_if.awid, m0_if.awaddr, m0_if.awlen, m0_if.awsize, m0_if.awburst, m0_if.awlock,
            m0_if.awcache, m0_if.awprot, m0_if.awuser, m0_if.wdata, m0_if.wstrb, m0_if.wlast} =
           {s_if.awid, s_if.awaddr, s_if.awlen, s_if.awsize, s_if.awburst, s_if.awlock,
            s_if.awcache, s_if.awprot, s_if.awuser, s_if.wdata, s_if.wstrb, s_if.wlast};
    assign {m1_if.awid, m1_if.awaddr, m1_if.awlen, m1_if.awsize, m1_if.awburst, m1_if.awlock,
            m1_if.awcache, m1_if.awprot, m1_if.awuser, m1_if.wdata, m1_if.wstrb, m1_if.wlast} =
           {s_if.awid, s_if.awaddr, s_if.awlen, s_if.awsize, s_if.awburst, s_if.awlock,
            s_if.awcache, s_if.awprot, s_if.awuser, s_if.wdata, s_if.wstrb, s_if.wlast};
    assign {m0_if.arid, m0_if.araddr, m0_if.arlen, m0_if.arsize, m0_if.arburst, m0_if.arlock,
            m0_if.arcache, m0_if.arprot, m0_if.aruser} =
           {s_if.arid, s_if.araddr, s_if.arlen, s_if.arsize, s_if.arburst, s_if.arlock,
            s_if.arcache, s_if.arprot, s_if.aruser};
    assign {m1_if.arid, m1_if.araddr, m1_if.arlen, m1_if.arsize, m1_if.arburst, m1_if.arlock,
            m1_if.arcache, m1_if.arprot, m1_if.aruser} =
           {s_if.arid, s_if.araddr, s_if.arlen, s_if.arsize, s_if.arburst, s_if.arlock,
            s_if.arcache, s_if.arprot, s_if.aruser};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            wsel_q    <= TGT_DECERR;
            rsel_q    <= TGT_DECERR;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            wsel_q    <= wsel_d;
            rsel_q    <= rsel_d;
        end
    end

    // Handshake steering is gated by i_rst so every valid/ready drops with reset, not a clock later.
    always_comb begin
        w_state_d = w_state_q;
        wsel_d    = wsel_q;
        m0_if.awvalid = 1'b0; m1_if.awvalid = 1'b0; de_awvalid = 1'b0;
        m0_if.wvalid  = 1'b0; m1_if.wvalid  = 1'b0; de_wvalid  = 1'b0;
        m0_if.bready  = 1'b0; m1_if.bready  = 1'b0; de_bready  = 1'b0;
        s_if.awready  = 1'b0; s_if.wready   = 1'b0; s_if.bvalid = 1'b0;
        if (!i_rst) begin
            case (w_state_q)
                W_IDLE: begin
                    case (aw_tgt)
                        TGT_X2P:  begin m0_if.awvalid = s_if.awvalid; s_if.awready = m0_if.awready; end
                        TGT_UART: begin m1_if.awvalid = s_if.awvalid; s_if.awready = m1_if.awready; end
                        default:  begin de_awvalid    = s_if.awvalid; s_if.awready = de_awready;    end
                    endcase
                    if (s_if.awvalid && s_if.awready) begin wsel_d = aw_tgt; w_state_d = W_DATA; end
                end
                W_DATA: begin
                    case (wsel_q)
                        TGT_X2P:  begin m0_if.wvalid = s_if.wvalid; s_if.wready = m0_if.wready; end
                        TGT_UART: begin m1_if.wvalid = s_if.wvalid; s_if.wready = m1_if.wready; end
                        default:  begin de_wvalid    = s_if.wvalid; s_if.wready = de_wready;    end
                    endcase
                    if (s_if.wvalid && s_if.wready && s_if.wlast) w_state_d = W_RESP;
                end
                default: begin
                    case (wsel_q)
                        TGT_X2P:  begin m0_if.bready = s_if.bready; s_if.bvalid = m0_if.bvalid; end
                        TGT_UART: begin m1_if.bready = s_if.bready; s_if.bvalid = m1_if.bvalid; end
                        default:  begin de_bready    = s_if.bready; s_if.bvalid = de_bvalid;    end
                    endcase
                    if (s_if.bvalid && s_if.bready) w_state_d = W_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        rsel_d    = rsel_q;
        m0_if.arvalid = 1'b0; m1_if.arvalid = 1'b0; de_arvalid = 1'b0;
        m0_if.rready  = 1'b0; m1_if.rready  = 1'b0; de_rready  = 1'b0;
        s_if.arready  = 1'b0; s_if.rvalid   = 1'b0;
        if (!i_rst) begin
            if (r_state_q == R_IDLE) begin
                case (ar_tgt)
                    TGT_X2P:  begin m0_if.arvalid = s_if.arvalid; s_if.arready = m0_if.arready; end
                    TGT_UART: begin m1_if.arvalid = s_if.arvalid; s_if.arready = m1_if.arready; end
                    default:  begin de_arvalid    = s_if.arvalid; s_if.arready = de_arready;    end
                endcase
                if (s_if.arvalid && s_if.arready) begin rsel_d = ar_tgt; r_state_d = R_DATA; end
            end else begin
                case (rsel_q)
                    TGT_X2P:  begin m0_if.rready = s_if.rready; s_if.rvalid = m0_if.rvalid; end
                    TGT_UART: begin m1_if.rready = s_if.rready; s_if.rvalid = m1_if.rvalid; end
                    default:  begin de_rready    = s_if.rready; s_if.rvalid = de_rvalid;    end
                endcase
                if (s_if.rvalid && s_if.rready && s_if.rlast) r_state_d = R_IDLE;
            end
        end
    end

    always_comb begin
        s_if.bid = de_bid;  s_if.bresp = de_bresp;
        case (wsel_q)
            TGT_X2P:  begin s_if.bid = m0_if.bid; s_if.bresp = m0_if.bresp; end
            TGT_UART: begin s_if.bid = m1_if.bid; s_if.bresp = m1_if.bresp; end
            default:  ;
        endcase
    end

    always_comb begin
        s_if.rid = de_rid;  s_if.rdata = de_rdata;  s_if.rresp = de_rresp;  s_if.rlast = de_rlast;
        case (rsel_q)
            TGT_X2P:  begin s_if.rid = m0_if.rid; s_if.rdata = m0_if.rdata; s_if.rresp = m0_if.rresp; s_if.rlast = m0_if.rlast; end
            TGT_UART: begin s_if.rid = m1_if.rid; s_if.rdata = m1_if.rdata; s_if.rresp = m1_if.rresp; s_if.rlast = m1_if.rlast; end
            default:  ;
        endcase
    end

    miet_ic_decerr_slave #(.ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_decerr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .awvalid (de_awvalid),
        .awready (de_awready),
        .awid    (s_if.awid),
        .wvalid  (de_wvalid),
        .wready  (de_wready),
        .wlast   (s_if.wlast),
        .bvalid  (de_bvalid),
        .bready  (de_bready),
        .bid     (de_bid),
        .bresp   (de_bresp),
        .arvalid (de_arvalid),
        .arready (de_arready),
        .arid    (s_if.arid),
        .arlen   (s_if.arlen),
        .rvalid  (de_rvalid),
        .rready  (de_rready),
        .rid     (de_rid),
        .rdata   (de_rdata),
        .rresp   (de_rresp),
        .rlast   (de_rlast)
    );
endmodule

// File: tb/tb_miet_axi_interconnect.sv
// Directed bench for the DMEM interconnect: routing, DECERR responder, backpressure, mid-burst reset.
module tb_miet_axi_interconnect;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    miet_axi_interconnect_if s_if ();
    miet_axi_interconnect_if m0_if ();
    miet_axi_interconnect_if m1_if ();

    miet_axi_interconnect dut (
        .i_clk (clk),
        .i_rst (rst),
        .s_if  (s_if),
        .m0_if (m0_if),
        .m1_if (m1_if)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        s_if.awid = '0; s_if.awaddr = '0; s_if.awlen = '0; s_if.awsize = 3'd2; s_if.awburst = 2'b01;
        s_if.awlock = 1'b0; s_if.awcache = '0; s_if.awprot = '0; s_if.awuser = '0; s_if.awvalid = 1'b0;
        s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = 1'b0; s_if.wvalid = 1'b0; s_if.bready = 1'b0;
        s_if.arid = '0; s_if.araddr = '0; s_if.arlen = '0; s_if.arsize = 3'd2; s_if.arburst = 2'b01;
        s_if.arlock = 1'b0; s_if.arcache = '0; s_if.arprot = '0; s_if.aruser = '0; s_if.arvalid = 1'b0;
        s_if.rready = 1'b0;
        m0_if.awready = 1'b0; m0_if.wready = 1'b0; m0_if.bid = '0; m0_if.bresp = '0; m0_if.bvalid = 1'b0;
        m0_if.arready = 1'b0; m0_if.rid = '0; m0_if.rdata = '0; m0_if.rresp = '0; m0_if.rlast = 1'b0;
        m0_if.rvalid = 1'b0;
        m1_if.awready = 1'b0; m1_if.wready = 1'b0; m1_if.bid = '0; m1_if.bresp = '0; m1_if.bvalid = 1'b0;
        m1_if.arready = 1'b0; m1_if.rid = '0; m1_if.rdata = '0; m1_if.rresp = '0; m1_if.rlast = 1'b0;
        m1_if.rvalid = 1'b0;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        // Reset: outputs must stay quiet even with requests pending
        s_if.awvalid = 1'b1; s_if.arvalid = 1'b1; m0_if.awready = 1'b1; m0_if.arready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst m0_awvalid", m0_if.awvalid, 0);
        chk("rst m0_arvalid", m0_if.arvalid, 0);
        chk("rst s_awready", s_if.awready, 0);
        chk("rst s_arready", s_if.arready, 0);
        chk("rst s_bvalid", s_if.bvalid, 0);
        chk("rst s_rvalid", s_if.rvalid, 0);
        chk("rst s_rdata", s_if.rdata, 0);
        chk("rst s_bresp", s_if.bresp, 0);
        @(negedge clk);
        clr();
        rst = 1'b0;

        // 1: write to X2P
        @(negedge clk);
        s_if.awvalid = 1'b1; s_if.awaddr = 32'h0000_0010; s_if.awid = 4'd2;
        s_if.wvalid = 1'b1; s_if.wdata = 32'hA5A5_A5A5; s_if.wstrb = 4'hF; s_if.wlast = 1'b1;
        m0_if.awready = 1'b1; m0_if.wready = 1'b1; m1_if.awready = 1'b1; m1_if.wready = 1'b1;
        #1;
        chk("t1 m0_awvalid", m0_if.awvalid, 1);
        chk("t1 m1_awvalid", m1_if.awvalid, 0);
        chk("t1 s_awready", s_if.awready, 1);
        chk("t1 m0_awaddr", m0_if.awaddr, 32'h10);
        chk("t1 m0_wvalid idle", m0_if.wvalid, 0);
        @(negedge clk);
        s_if.awvalid = 1'b0;
        #1;
        chk("t1 m0_wvalid", m0_if.wvalid, 1);
        chk("t1 m1_wvalid", m1_if.wvalid, 0);
        chk("t1 m0_wdata", m0_if.wdata, 32'hA5A5_A5A5);
        chk("t1 m0_wstrb", m0_if.wstrb, 4'hF);
        chk("t1 s_wready", s_if.wready, 1);
        @(negedge clk);
        s_if.wvalid = 1'b0; s_if.bready = 1'b1;
        m0_if.bvalid = 1'b1; m0_if.bid = 4'd2; m0_if.bresp = 2'b00;
        #1;
        chk("t1 s_bvalid", s_if.bvalid, 1);
        chk("t1 s_bid", s_if.bid, 2);
        chk("t1 s_bresp", s_if.bresp, 0);
        chk("t1 m0_bready", m0_if.bready, 1);
        chk("t1 m1_bready", m1_if.bready, 0);
        @(negedge clk);
        clr();
        #1;
        chk("t1 s_bvalid done", s_if.bvalid, 0);

        // 2: single-beat read from UART
        @(negedge clk);
        s_if.arvalid = 1'b1; s_if.araddr = 32'h0000_1004; s_if.arid = 4'd3;
        m0_if.arready = 1'b1; m1_if.arready = 1'b1;
        #1;
        chk("t2 m1_arvalid", m1_if.arvalid, 1);
        chk("t2 m0_arvalid", m0_if.arvalid, 0);
        chk("t2 s_arready", s_if.arready, 1);
        @(negedge clk);
        s_if.arvalid = 1'b0; s_if.rready = 1'b1;
        m1_if.rvalid = 1'b1; m1_if.rid = 4'd3; m1_if.rdata = 32'h55; m1_if.rlast = 1'b1;
        #1;
        chk("t2 s_rvalid", s_if.rvalid, 1);
        chk("t2 s_rdata", s_if.rdata, 32'h55);
        chk("t2 s_rid", s_if.rid, 3);
        chk("t2 s_rlast", s_if.rlast, 1);
        chk("t2 m1_rready", m1_if.rready, 1);
        chk("t2 m0_rready", m0_if.rready, 0);
        @(negedge clk);
        clr();
        #1;
        chk("t2 s_rvalid done", s_if.rvalid, 0);

        // 3: unmapped 4-beat read answered by the DECERR responder
        @(negedge clk);
        s_if.arvalid = 1'b1; s_if.araddr = 32'h0000_2000; s_if.arlen = 8'd3; s_if.arid = 4'd6;
        m0_if.arready = 1'b1; m1_if.arready = 1'b1;
        #1;
        chk("t3 m0_arvalid", m0_if.arvalid, 0);
        chk("t3 m1_arvalid", m1_if.arvalid, 0);
        chk("t3 s_arready", s_if.arready, 1);
        @(negedge clk);
        s_if.arvalid = 1'b0; s_if.rready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            #1;
            chk("t3 s_rvalid", s_if.rvalid, 1);
            chk("t3 s_rdata", s_if.rdata, 0);
            chk("t3 s_rresp", s_if.rresp, 2'b11);
            chk("t3 s_rid", s_if.rid, 6);
            chk("t3 s_rlast", s_if.rlast, (b == 3) ? 1 : 0);
            chk("t3 m0_rready", m0_if.rready, 0);
            chk("t3 m1_rready", m1_if.rready, 0);
            @(negedge clk);
        end
        #1;
        chk("t3 s_rvalid done", s_if.rvalid, 0);
        clr();

        // 4: unmapped write gets DECERR with echoed id
        @(negedge clk);
        s_if.awvalid = 1'b1; s_if.awaddr = 32'h8000_0000; s_if.awid = 4'd5;
        s_if.wvalid = 1'b1; s_if.wlast = 1'b1; s_if.bready = 1'b1;
        m0_if.awready = 1'b1; m1_if.awready = 1'b1;
        #1;
        chk("t4 s_awready", s_if.awready, 1);
        chk("t4 m0_awvalid", m0_if.awvalid, 0);
        chk("t4 m1_awvalid", m1_if.awvalid, 0);
        @(negedge clk);
        s_if.awvalid = 1'b0; s_if.awid = 4'd0;
        #1;
        chk("t4 s_wready", s_if.wready, 1);
        chk("t4 m0_wvalid", m0_if.wvalid, 0);
        @(negedge clk);
        s_if.wvalid = 1'b0;
        #1;
        chk("t4 s_bvalid", s_if.bvalid, 1);
        chk("t4 s_bresp", s_if.bresp, 2'b11);
        chk("t4 s_bid", s_if.bid, 5);
        @(negedge clk);
        #1;
        chk("t4 s_bvalid done", s_if.bvalid, 0);
        clr();

        // 5: concurrent X2P write and UART read with 3-cycle backpressure
        @(negedge clk);
        s_if.awvalid = 1'b1; s_if.awaddr = 32'h20; s_if.awid = 4'd1;
        s_if.arvalid = 1'b1; s_if.araddr = 32'h1008; s_if.arid = 4'd4;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5 m0_awvalid", m0_if.awvalid, 1);
            chk("t5 m1_arvalid", m1_if.arvalid, 1);
            chk("t5 m1_awvalid", m1_if.awvalid, 0);
            chk("t5 m0_arvalid", m0_if.arvalid, 0);
            chk("t5 s_awready stall", s_if.awready, 0);
            chk("t5 s_arready stall", s_if.arready, 0);
            @(negedge clk);
        end
        m0_if.awready = 1'b1; m1_if.arready = 1'b1;
        #1;
        chk("t5 s_awready", s_if.awready, 1);
        chk("t5 s_arready", s_if.arready, 1);
        @(negedge clk);
        clr();
        s_if.wvalid = 1'b1; s_if.wdata = 32'h1234; s_if.wlast = 1'b1;
        m1_if.rvalid = 1'b1; m1_if.rdata = 32'h77; m1_if.rid = 4'd4; m1_if.rlast = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5 m0_wvalid", m0_if.wvalid, 1);
            chk("t5 m1_wvalid", m1_if.wvalid, 0);
            chk("t5 s_wready stall", s_if.wready, 0);
            chk("t5 s_rvalid", s_if.rvalid, 1);
            chk("t5 m1_rready stall", m1_if.rready, 0);
            chk("t5 m0_rready", m0_if.rready, 0);
            @(negedge clk);
        end
        m0_if.wready = 1'b1; s_if.rready = 1'b1;
        #1;
        chk("t5 s_wready", s_if.wready, 1);
        chk("t5 s_rdata", s_if.rdata, 32'h77);
        chk("t5 s_rid", s_if.rid, 4);
        chk("t5 m1_rready", m1_if.rready, 1);
        @(negedge clk);
        clr();
        s_if.bready = 1'b1; m0_if.bvalid = 1'b1; m0_if.bid = 4'd1;
        #1;
        chk("t5 s_bvalid", s_if.bvalid, 1);
        chk("t5 s_bid", s_if.bid, 1);
        chk("t5 s_rvalid done", s_if.rvalid, 0);
        @(negedge clk);
        clr();

        // 6: reset in W_DATA, then a clean UART write
        @(negedge clk);
        s_if.awvalid = 1'b1; s_if.awaddr = 32'h30; m0_if.awready = 1'b1;
        @(negedge clk);
        s_if.awvalid = 1'b0; s_if.wvalid = 1'b1; s_if.wlast = 1'b0; m0_if.wready = 1'b1;
        #1;
        chk("t6 m0_wvalid pre", m0_if.wvalid, 1);
        rst = 1'b1;
        #1;
        chk("t6 m0_wvalid rst", m0_if.wvalid, 0);
        chk("t6 s_wready rst", s_if.wready, 0);
        chk("t6 s_awready rst", s_if.awready, 0);
        @(negedge clk);
        clr();
        rst = 1'b0;
        @(negedge clk);
        s_if.awvalid = 1'b1; s_if.awaddr = 32'h1000; s_if.awid = 4'd7;
        s_if.wvalid = 1'b1; s_if.wlast = 1'b1; s_if.wdata = 32'hCAFE;
        m1_if.awready = 1'b1; m1_if.wready = 1'b1;
        #1;
        chk("t6 m1_awvalid", m1_if.awvalid, 1);
        chk("t6 m0_awvalid", m0_if.awvalid, 0);
        @(negedge clk);
        s_if.awvalid = 1'b0;
        #1;
        chk("t6 m1_wvalid", m1_if.wvalid, 1);
        chk("t6 s_wready", s_if.wready, 1);
        @(negedge clk);
        s_if.wvalid = 1'b0; s_if.bready = 1'b1;
        m1_if.bvalid = 1'b1; m1_if.bid = 4'd7;
        #1;
        chk("t6 s_bvalid", s_if.bvalid, 1);
        chk("t6 s_bid", s_if.bid, 7);
        chk("t6 s_bresp", s_if.bresp, 0);
        @(negedge clk);
        clr();
        #1;
        chk("t6 s_bvalid done", s_if.bvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
